game_sequencer: RTL and testbench

GAME_SEQUENCER -- requirements
Module: game_sequencer

---
 rtl/game_sequencer.sv | 158 +++++++++++++++
 tb/tb_game_sequencer.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/game_sequencer.sv
// ============================================================================
// Module      : game_sequencer
// Description : Breakout-style game flow FSM with lives, serve and paddle control.
//               Optional pause support is enabled with macro GAME_PAUSE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module game_sequencer #(
  parameter int LIVES    = 3,
  parameter int PAD_STEP = 5,
  parameter int PAD_MIN  = 100,
  parameter int PAD_MAX  = 370,
  parameter int PAD_INIT = 235
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       key_start,
  input  logic       key_pause,
  input  logic       key_left,
  input  logic       key_right,
  input  logic       ball_lost,
  input  logic       bricks_clear,
  output logic [2:0] state,
  output logic       step_en,
  output logic       load_level,
  output logic       serve,
  output logic [1:0] lives,
  output logic [9:0] board_x
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SERVE = 3'd1,
    S_PLAY  = 3'd2,
    S_PAUSE = 3'd3,
    S_MISS  = 3'd4,
    S_WIN   = 3'd5,
    S_OVER  = 3'd6
  } state_t;

  localparam logic [10:0] C_MIN  = 11'(PAD_MIN);
  localparam logic [10:0] C_MAX  = 11'(PAD_MAX);
  localparam logic [10:0] C_STEP = 11'(PAD_STEP);

  state_t     state_q, state_d;
  logic [1:0] lives_q, lives_d;
  logic [9:0] board_x_q, board_x_d;
  logic       load_level_q, load_level_d;
  logic       start_prev_q, pause_prev_q;

  logic        start_press;
  logic        pause_press;
  logic [10:0] x_ext;
  logic [10:0] x_inc;
  logic [10:0] x_dec;

  assign start_press = key_start & ~start_prev_q;
  assign pause_press = key_pause & ~pause_prev_q;

`ifndef GAME_PAUSE_EN
  logic unused_pause;
  assign unused_pause = pause_press;
`endif

  // Widen to 11 bits so saturation is decided before any 10-bit wrap.
  assign x_ext = {1'b0, board_x_q};
  assign x_inc = x_ext + C_STEP;
  assign x_dec = x_ext - C_STEP;

  always_comb begin
    board_x_d = board_x_q;
    if (tick && (state_q == S_SERVE || state_q == S_PLAY)) begin
      if (key_left && !key_right) begin
        board_x_d = (x_ext < C_MIN + C_STEP) ? C_MIN[9:0] : x_dec[9:0];
      end else if (key_right && !key_left) begin
        board_x_d = (x_inc > C_MAX) ? C_MAX[9:0] : x_inc[9:0];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    lives_d      = lives_q;
    load_level_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_press) begin
          state_d      = S_SERVE;
          lives_d      = 2'(LIVES);
          load_level_d = 1'b1;
        end
      end
      S_SERVE: begin
        if (start_press) state_d = S_PLAY;
      end
      S_PLAY: begin
        if (tick && bricks_clear) begin
          state_d = S_WIN;
        end else if (tick && ball_lost) begin
          state_d = S_MISS;
`ifdef GAME_PAUSE_EN
        end else if (pause_press) begin
          state_d = S_PAUSE;
`endif
        end
      end
`ifdef GAME_PAUSE_EN
      S_PAUSE: begin
        if (pause_press) state_d = S_PLAY;
      end
`endif
      S_MISS: begin
        if (lives_q <= 2'd1) begin
          lives_d = 2'd0;
          state_d = S_OVER;
        end else begin
          lives_d = lives_q - 2'd1;
          state_d = S_SERVE;
        end
      end
      S_WIN, S_OVER: begin
        if (start_press) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Previous-key registers reset high so keys held through reset are not presses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      lives_q      <= 2'(LIVES);
      board_x_q    <= 10'(PAD_INIT);
      load_level_q <= 1'b0;
      start_prev_q <= 1'b1;
      pause_prev_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      lives_q      <= lives_d;
      board_x_q    <= board_x_d;
      load_level_q <= load_level_d;
      start_prev_q <= key_start;
      pause_prev_q <= key_pause;
    end
  end

  assign state      = state_q;
  assign lives      = lives_q;
  assign board_x    = board_x_q;
  assign load_level = load_level_q;
  assign serve      = (state_q == S_SERVE);
  assign step_en    = (state_q == S_PLAY) & tick;

endmodule

`default_nettype wire

// File: tb/tb_game_sequencer.sv
// ============================================================================
// Module      : tb_game_sequencer
// Description : Directed and random self-checking bench for game_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_game_sequencer;

`ifdef GAME_PAUSE_EN
  localparam int PAUSE_EN = 1;
`else
  localparam int PAUSE_EN = 0;
`endif

  localparam int M_IDLE = 0, M_SERVE = 1, M_PLAY = 2, M_PAUSE = 3;
  localparam int M_MISS = 4, M_WIN = 5, M_OVER = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, tick, key_start, key_pause, key_left, key_right;
  logic       ball_lost, bricks_clear;
  logic [2:0] state;
  logic       step_en, load_level, serve;
  logic [1:0] lives;
  logic [9:0] board_x;

  game_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .tick        (tick),
    .key_start   (key_start),
    .key_pause   (key_pause),
    .key_left    (key_left),
    .key_right   (key_right),
    .ball_lost   (ball_lost),
    .bricks_clear(bricks_clear),
    .state       (state),
    .step_en     (step_en),
    .load_level  (load_level),
    .serve       (serve),
    .lives       (lives),
    .board_x     (board_x)
  );

  int checks = 0;
  int errors = 0;

  // Reference game state
  int m_state, m_lives, m_x, m_load, m_sprev, m_pprev;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    int sp, pp;
    if (rst) begin
      m_state = M_IDLE; m_lives = 3; m_x = 235; m_load = 0;
      m_sprev = 1; m_pprev = 1;
      return;
    end
    sp = (key_start && m_sprev == 0) ? 1 : 0;
    pp = (PAUSE_EN == 1 && key_pause && m_pprev == 0) ? 1 : 0;
    m_load = 0;
    if (tick && (m_state == M_SERVE || m_state == M_PLAY)) begin
      if (key_left && !key_right)  m_x = (m_x - 5 < 100) ? 100 : m_x - 5;
      if (key_right && !key_left)  m_x = (m_x + 5 > 370) ? 370 : m_x + 5;
    end
    case (m_state)
      M_IDLE:  if (sp == 1) begin m_state = M_SERVE; m_lives = 3; m_load = 1; end
      M_SERVE: if (sp == 1) m_state = M_PLAY;
      M_PLAY: begin
        if (tick && bricks_clear)   m_state = M_WIN;
        else if (tick && ball_lost) m_state = M_MISS;
        else if (pp == 1)           m_state = M_PAUSE;
      end
      M_PAUSE: if (pp == 1) m_state = M_PLAY;
      M_MISS: begin
        if (m_lives > 0) m_lives = m_lives - 1;
        m_state = (m_lives == 0) ? M_OVER : M_SERVE;
      end
      default: if (sp == 1) m_state = M_IDLE;
    endcase
    m_sprev = key_start ? 1 : 0;
    m_pprev = key_pause ? 1 : 0;
  endtask

  // One clock: check combinational outputs, clock, then check registered outputs.
  task automatic cycle();
    #2;
    chk("step_en", step_en, (m_state == M_PLAY && tick) ? 1 : 0);
    chk("serve", serve, (m_state == M_SERVE) ? 1 : 0);
    @(posedge clk);
    model_edge();
    #1;
    chk("state", state, m_state);
    chk("lives", lives, m_lives);
    chk("board_x", board_x, m_x);
    chk("load_level", load_level, m_load);
  endtask

  task automatic press_start();
    key_start = 1'b1; cycle();
    key_start = 1'b0; cycle();
  endtask

  task automatic press_pause();
    key_pause = 1'b1; cycle();
    key_pause = 1'b0; cycle();
  endtask

  int exp_x[4] = '{365, 370, 370, 370};
  int x_hold;

  initial begin
    rst = 1'b1; tick = 1'b0; key_start = 1'b0; key_pause = 1'b0;
    key_left = 1'b0; key_right = 1'b0; ball_lost = 1'b0; bricks_clear = 1'b0;
    @(posedge clk);
    model_edge();
    #1;
    cycle();
    chk("rst_state", state, 0);
    chk("rst_lives", lives, 3);
    chk("rst_board_x", board_x, 235);
    chk("rst_load", load_level, 0);
    rst = 1'b0;
    cycle();

    // Game start
    key_start = 1'b1; cycle();
    chk("start_state", state, 1);
    chk("start_load", load_level, 1);
    chk("start_lives", lives, 3);
    chk("start_serve", serve, 1);
    chk("start_step_en", step_en, 0);
    key_start = 1'b0; cycle();
    chk("load_pulse_end", load_level, 0);

    // Move paddle in SERVE to 360, then to PLAY and push against right limit
    tick = 1'b1; key_right = 1'b1;
    for (int i = 0; i < 25; i++) cycle();
    chk("serve_move_x", board_x, 360);
    tick = 1'b0; key_right = 1'b0;
    press_start();
    chk("play_state", state, 2);
    tick = 1'b1; key_right = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("right_sat_x", board_x, exp_x[i]);
    end
    key_right = 1'b0;

    // Win has priority over miss
    ball_lost = 1'b1; bricks_clear = 1'b1; cycle();
    chk("win_state", state, 5);
    chk("win_lives", lives, 3);
    ball_lost = 1'b0; bricks_clear = 1'b0; tick = 1'b0;

    // Three misses to game over
    press_start();
    press_start();
    for (int i = 0; i < 3; i++) begin
      press_start();
      tick = 1'b1; ball_lost = 1'b1; cycle();
      chk("miss_state", state, 4);
      tick = 1'b0; ball_lost = 1'b0; cycle();
      chk("miss_lives", lives, 2 - i);
    end
    chk("over_state", state, 6);
    tick = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("over_step_en", step_en, 0);
    end
    tick = 1'b0;

    // Pause
    press_start();
    press_start();
    press_start();
    press_pause();
    chk("pause_state", state, (PAUSE_EN == 1) ? 3 : 2);
    tick = 1'b1; key_left = 1'b1;
    for (int i = 0; i < 3; i++) cycle();
    tick = 1'b0; key_left = 1'b0;
    press_pause();
    chk("unpause_state", state, 2);

    // Start held through reset is not a press
    key_start = 1'b1; rst = 1'b1;
    cycle(); cycle();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) cycle();
    chk("held_start_state", state, 0);
    key_start = 1'b0; cycle();
    key_start = 1'b1; cycle();
    chk("repress_state", state, 1);
    key_start = 1'b0; cycle();

    // Random play
    for (int i = 0; i < 3000; i++) begin
      rst          = ($urandom_range(0, 299) == 0);
      tick         = ($urandom_range(0, 2) == 0);
      key_start    = ($urandom_range(0, 3) == 0);
      key_pause    = ($urandom_range(0, 5) == 0);
      key_left     = ($urandom_range(0, 1) == 0);
      key_right    = ($urandom_range(0, 1) == 0);
      ball_lost    = ($urandom_range(0, 7) == 0);
      bricks_clear = ($urandom_range(0, 24) == 0);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
